// File: rtl/serial_lane_arbiter.sv
// -----------------------------------------------------------------------------
// serial_lane_arbiter
//
// Lets NUM_REQ parallel-word producers share one MSB-first serial lane. In
// IDLE, a round-robin arbiter picks one valid requester and accepts its word
// in the same cycle with a one-hot req_ready. The word is then shifted out
// one bit per clock, tagged with start/end-of-frame flags and the source
// index. After each frame the lane can stay quiet for GAP_CYCLES cycles
// before the next arbitration.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous reset, active-high
//   req_valid     [NUM_REQ]        requester i has a word on offer
//   req_data      [NUM_REQ*WIDTH]  word of requester i at [i*WIDTH +: WIDTH]
//   req_ready     [NUM_REQ]        one-hot accept; a word moves when valid&ready
//   serial_out    current frame bit, MSB first; 0 when no frame is active
//   serial_valid  serial_out carries a frame bit
//   serial_sop    first bit of the frame (MSB)
//   serial_eop    last bit of the frame (LSB)
//   serial_id     index of the requester that owns the current or last frame
//   busy          arbiter is not in IDLE
// -----------------------------------------------------------------------------
module serial_lane_arbiter #(
  parameter int WIDTH      = 8,
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]     req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         serial_out,
  output logic                         serial_valid,
  output logic                         serial_sop,
  output logic                         serial_eop,
  output logic [$clog2(NUM_REQ)-1:0]   serial_id,
  output logic                         busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int BIT_W = $clog2(WIDTH);
  // The gap counter still needs one bit when GAP_CYCLES is 0; GAP is then unreachable.
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [BIT_W-1:0] BIT_FIRST = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [ID_W-1:0]  ID_LAST   = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_shift;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_id;

  logic               w_found;
  logic [ID_W-1:0]    w_winner;
  logic [ID_W-1:0]    w_next_ptr;
  logic               w_accept;

  // Round-robin search: first valid requester starting at r_rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx      = 0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_found && req_valid[idx]) begin
        w_found  = 1'b1;
        w_winner = ID_W'(idx);
      end
    end
  end

  assign w_next_ptr = (w_winner == ID_LAST) ? '0 : w_winner + ID_W'(1);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the blocks are evaluated in.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and lane outputs.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    req_ready    = '0;
    serial_valid = 1'b0;
    serial_out   = 1'b0;
    serial_sop   = 1'b0;
    serial_eop   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Reset is synchronous, so the grant is masked while it is asserted:
        // no requester may believe its word was taken during reset.
        if (w_found && !rst) begin
          req_ready[w_winner] = 1'b1;
          w_accept            = 1'b1;
          w_state_nxt         = S_SHIFT;
        end
      end
      S_SHIFT: begin
        serial_valid = 1'b1;
        serial_out   = r_shift[WIDTH-1];
        serial_sop   = (r_bit_cnt == BIT_FIRST);
        if (r_bit_cnt == '0) begin
          serial_eop  = 1'b1;
          w_state_nxt = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == '0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: captured word, counters, priority pointer, owner tag.
  always_ff @(posedge clk) begin
    // NOTE: every register here is reset, so an aborted frame leaves nothing
    // behind; there is no storage array that would need to skip reset.
    if (rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_rr_ptr  <= '0;
      r_id      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shift   <= req_data[int'(w_winner)*WIDTH +: WIDTH];
            r_id      <= w_winner;
            r_bit_cnt <= BIT_FIRST;
            r_rr_ptr  <= w_next_ptr;
          end
        end
        S_SHIFT: begin
          r_shift <= {r_shift[WIDTH-2:0], 1'b0};
          if (r_bit_cnt != '0) r_bit_cnt <= r_bit_cnt - BIT_W'(1);
          else                 r_gap_cnt <= GAP_LAST;
        end
        S_GAP: begin
          if (r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign serial_id = r_id;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_lane_arbiter.sv
// -----------------------------------------------------------------------------
// tb_serial_lane_arbiter
//
// Scoreboard bench for serial_lane_arbiter. Stimulus pushes the expected grant
// index and the expected serial beats (bit, sop, eop, id) of each frame into
// queues; monitor processes pop and compare whenever a DUT accepts a word or
// presents a valid serial bit. Two instances: GAP_CYCLES=0 for most scenarios
// and GAP_CYCLES=3 for the inter-frame gap.
// -----------------------------------------------------------------------------
module tb_serial_lane_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  typedef struct packed {
    logic       bit_v;
    logic       sop;
    logic       eop;
    logic [1:0] id;
  } beat_t;

  logic         clk;
  logic         rst;

  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           serial_out, serial_valid, serial_sop, serial_eop, busy;
  logic [1:0]     serial_id;

  logic [N-1:0]   g_req_valid;
  logic [N*W-1:0] g_req_data;
  logic [N-1:0]   g_req_ready;
  logic           g_serial_out, g_serial_valid, g_serial_sop, g_serial_eop, g_busy;
  logic [1:0]     g_serial_id;

  serial_lane_arbiter #(.WIDTH(W), .NUM_REQ(N), .GAP_CYCLES(0)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .serial_out(serial_out), .serial_valid(serial_valid),
    .serial_sop(serial_sop), .serial_eop(serial_eop),
    .serial_id(serial_id), .busy(busy)
  );

  serial_lane_arbiter #(.WIDTH(W), .NUM_REQ(N), .GAP_CYCLES(3)) u_gap (
    .clk(clk), .rst(rst),
    .req_valid(g_req_valid), .req_data(g_req_data), .req_ready(g_req_ready),
    .serial_out(g_serial_out), .serial_valid(g_serial_valid),
    .serial_sop(g_serial_sop), .serial_eop(g_serial_eop),
    .serial_id(g_serial_id), .busy(g_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  beat_t      exp_beats[$];
  logic [1:0] exp_grants[$];
  beat_t      g_exp_beats[$];
  logic [1:0] g_exp_grants[$];

  int acc_count = 0;
  int last_acc  = 0;
  int acc_cyc_q[$];
  int g_acc_q[$];
  int g_sop_q[$];
  int g_eop_q[$];
  int g_gap_cnt = 0;
  logic [N-1:0] seen_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input bit to_g, input logic [1:0] id,
                            input logic [7:0] data, input int nbits);
    beat_t b;
    for (int i = 0; i < nbits; i++) begin
      b.bit_v = data[7-i];
      b.sop   = (i == 0);
      b.eop   = (i == 7);
      b.id    = id;
      if (to_g) g_exp_beats.push_back(b);
      else      exp_beats.push_back(b);
    end
    if (to_g) g_exp_grants.push_back(id);
    else      exp_grants.push_back(id);
  endtask

  // Monitor for the GAP_CYCLES=0 instance.
  always @(negedge clk) begin
    beat_t e;
    logic [1:0] g;
    if ((req_valid & req_ready) != '0) begin
      acc_count++;
      last_acc = cyc;
      acc_cyc_q.push_back(cyc);
      if (exp_grants.size() == 0) begin
        check("unexpected_accept", 32'(req_valid & req_ready), 32'd0);
      end else begin
        g = exp_grants.pop_front();
        check("grant_onehot", 32'(req_ready), 32'(4'b0001 << g));
      end
    end
    if (serial_valid === 1'b1) begin
      if (exp_beats.size() == 0) begin
        check("unexpected_beat", 32'(serial_valid), 32'd0);
      end else begin
        e = exp_beats.pop_front();
        check("beat_bit", 32'(serial_out), 32'(e.bit_v));
        check("beat_sop", 32'(serial_sop), 32'(e.sop));
        check("beat_eop", 32'(serial_eop), 32'(e.eop));
        check("beat_id",  32'(serial_id),  32'(e.id));
        if (e.sop) check("sop_latency", 32'(cyc - last_acc), 32'd1);
        if (e.eop) check("eop_latency", 32'(cyc - last_acc), 32'(W));
      end
    end
  end

  // Monitor for the GAP_CYCLES=3 instance.
  always @(negedge clk) begin
    beat_t e;
    logic [1:0] g;
    if ((g_req_valid & g_req_ready) != '0) begin
      g_acc_q.push_back(cyc);
      if (g_exp_grants.size() == 0) begin
        check("g_unexpected_accept", 32'(g_req_valid & g_req_ready), 32'd0);
      end else begin
        g = g_exp_grants.pop_front();
        check("g_grant_onehot", 32'(g_req_ready), 32'(4'b0001 << g));
      end
    end
    if (g_serial_valid === 1'b1) begin
      if (g_exp_beats.size() == 0) begin
        check("g_unexpected_beat", 32'(g_serial_valid), 32'd0);
      end else begin
        e = g_exp_beats.pop_front();
        check("g_beat_bit", 32'(g_serial_out), 32'(e.bit_v));
        check("g_beat_sop", 32'(g_serial_sop), 32'(e.sop));
        check("g_beat_eop", 32'(g_serial_eop), 32'(e.eop));
        check("g_beat_id",  32'(g_serial_id),  32'(e.id));
        if (e.sop) g_sop_q.push_back(cyc);
        if (e.eop) g_eop_q.push_back(cyc);
      end
    end
    if (g_busy === 1'b1 && g_serial_valid === 1'b0) begin
      g_gap_cnt++;
      check("g_gap_out_zero", 32'(g_serial_out), 32'd0);
    end
  end

  task automatic wait_acc(input int target, input int budget);
    int n;
    n = 0;
    while (acc_count < target && n < budget) begin
      @(negedge clk);
      seen_ready |= req_ready;
      n++;
    end
    check("wait_accept", 32'(acc_count), 32'(target));
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_beats.size() != 0 || exp_grants.size() != 0 || busy !== 1'b0 ||
            g_exp_beats.size() != 0 || g_exp_grants.size() != 0 || g_busy !== 1'b0) &&
           n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_beats",  32'(exp_beats.size() + g_exp_beats.size()), 32'd0);
    check("drain_grants", 32'(exp_grants.size() + g_exp_grants.size()), 32'd0);
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int base;
    rst         = 1'b1;
    req_valid   = '1;
    req_data    = '0;
    g_req_valid = '0;
    g_req_data  = '0;
    seen_ready  = '0;

    // T1: reset held while every requester is valid.
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      check("t1_ready",  32'(req_ready),    32'd0);
      check("t1_valid",  32'(serial_valid), 32'd0);
      check("t1_busy",   32'(busy),         32'd0);
    end
    @(posedge clk); #1;
    req_valid = '0;
    rst       = 1'b0;
    @(negedge clk);
    check("t1_id",  32'(serial_id),  32'd0);
    check("t1_out", 32'(serial_out), 32'd0);

    // T2: single word from requester 2; ready lasts exactly one cycle.
    push_frame(1'b0, 2'd2, 8'hA5, 8);
    @(posedge clk); #1;
    req_data[2*W +: W] = 8'hA5;
    req_valid          = 4'b0100;
    @(negedge clk);
    check("t2_ready", 32'(req_ready), 32'(4'b0100));
    @(negedge clk);
    check("t2_ready_once", 32'(req_ready), 32'd0);
    check("t2_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    req_valid = '0;
    wait_drain(40);

    // T3: fairness with all four held valid after a fresh reset.
    reset_pulse();
    acc_cyc_q.delete();
    base = acc_count;
    push_frame(1'b0, 2'd0, 8'h10, 8);
    push_frame(1'b0, 2'd1, 8'h11, 8);
    push_frame(1'b0, 2'd2, 8'h12, 8);
    push_frame(1'b0, 2'd3, 8'h13, 8);
    push_frame(1'b0, 2'd0, 8'h10, 8);
    @(posedge clk); #1;
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'b1111;
    wait_acc(base + 5, 80);
    @(posedge clk); #1;
    req_valid = '0;
    wait_drain(40);
    check("t3_accepts", 32'(acc_cyc_q.size()), 32'd5);
    if (acc_cyc_q.size() == 5) begin
      for (int i = 1; i < 5; i++)
        check("t3_period", 32'(acc_cyc_q[i] - acc_cyc_q[i-1]), 32'd9);
    end

    // T4: GAP_CYCLES=3 instance, requester 1 back-to-back.
    push_frame(1'b1, 2'd1, 8'h3C, 8);
    push_frame(1'b1, 2'd1, 8'hC3, 8);
    @(posedge clk); #1;
    g_req_data[1*W +: W] = 8'h3C;
    g_req_valid          = 4'b0010;
    for (int n = 0; n < 10 && g_acc_q.size() < 1; n++) @(negedge clk);
    @(posedge clk); #1;
    g_req_data[1*W +: W] = 8'hC3;
    for (int n = 0; n < 30 && g_acc_q.size() < 2; n++) @(negedge clk);
    @(posedge clk); #1;
    g_req_valid = '0;
    wait_drain(40);
    check("t4_accepts", 32'(g_acc_q.size()), 32'd2);
    if (g_acc_q.size() == 2 && g_sop_q.size() == 2 && g_eop_q.size() == 2) begin
      check("t4_period",   32'(g_acc_q[1] - g_acc_q[0]), 32'd12);
      check("t4_eop_sop",  32'(g_sop_q[1] - g_eop_q[0]), 32'd5);
    end
    check("t4_gap_cycles", 32'(g_gap_cnt), 32'd6);

    // T5: reset during the 4th bit of a frame from requester 2 (rr_ptr is 1).
    push_frame(1'b0, 2'd2, 8'h96, 4);
    @(posedge clk); #1;
    req_data[2*W +: W] = 8'h96;
    req_valid          = 4'b0100;
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_valid", 32'(serial_valid), 32'd0);
    check("t5_busy",  32'(busy),         32'd0);
    check("t5_id",    32'(serial_id),    32'd0);
    check("t5_out",   32'(serial_out),   32'd0);
    check("t5_eop",   32'(serial_eop),   32'd0);
    check("t5_partial_consumed", 32'(exp_beats.size()), 32'd0);
    push_frame(1'b0, 2'd0, 8'h81, 8);
    @(posedge clk); #1;
    req_data[0*W +: W] = 8'h81;
    req_valid          = 4'b0101;
    @(negedge clk);
    check("t5_ready_req0", 32'(req_ready), 32'(4'b0001));
    @(posedge clk); #1;
    req_valid = '0;
    wait_drain(40);

    // T6: rr_ptr moved to 2 via a grant to 1, then only 1 and 3 valid.
    push_frame(1'b0, 2'd1, 8'h5A, 8);
    @(posedge clk); #1;
    req_data[1*W +: W] = 8'h5A;
    req_valid          = 4'b0010;
    @(negedge clk);
    check("t6_ready_req1", 32'(req_ready), 32'(4'b0010));
    @(posedge clk); #1;
    req_valid = '0;
    wait_drain(40);
    base = acc_count;
    seen_ready = '0;
    push_frame(1'b0, 2'd3, 8'hC7, 8);
    push_frame(1'b0, 2'd1, 8'h3E, 8);
    @(posedge clk); #1;
    req_data[1*W +: W] = 8'h3E;
    req_data[3*W +: W] = 8'hC7;
    req_valid          = 4'b1010;
    wait_acc(base + 2, 40);
    @(posedge clk); #1;
    req_valid = '0;
    wait_drain(40);
    check("t6_no_ready_0_2", 32'(seen_ready & 4'b0101), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
